seq_mdu: RTL

SEQ_MDU -- requirements
Module: seq_mdu

---
 rtl/seq_mdu_pkg.sv | 21 ++
 rtl/seq_mdu_if.sv | 22 ++
 rtl/seq_mdu_step.sv | 39 +++
 rtl/seq_mdu.sv | 88 ++++++++
 4 files changed

// File: rtl/seq_mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   - FSM state encoding (IDLE=0, RUN=1, WB=2)
//   - operation codes (all unsigned)
//   - op-class helper used to steer the iteration step
package seq_mdu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [1:0] OP_MUL  = 2'b00;  // product, low half
  localparam logic [1:0] OP_MULH = 2'b01;  // product, high half
  localparam logic [1:0] OP_DIV  = 2'b10;  // quotient
  localparam logic [1:0] OP_REM  = 2'b11;  // remainder

  // DIV and REM share the restoring-divide datapath; MUL/MULH share shift-add.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/seq_mdu_if.sv
// Request / register-file write bus of seq_mdu.
//   master side (issuer): drives start, op, a, b, dst; observes busy, done, we, wa, wd
//   slave side  (seq_mdu): the reverse
interface seq_mdu_if #(
  parameter int dataWidth = 4,
  parameter int addressN  = 3
);
  logic                 start;
  logic [1:0]           op;
  logic [dataWidth-1:0] a;
  logic [dataWidth-1:0] b;
  logic [addressN-1:0]  dst;

  logic                 busy;
  logic                 done;
  logic                 we;
  logic [addressN-1:0]  wa;
  logic [dataWidth-1:0] wd;

  modport master (output start, op, a, b, dst, input  busy, done, we, wa, wd);
  modport slave  (input  start, op, a, b, dst, output busy, done, we, wa, wd);
endinterface

// File: rtl/seq_mdu_step.sv
// mdu_step: one combinational iteration of the multiply/divide datapath.
//   i_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   i_hi   : upper register (multiply: product high half, divide: remainder)
//   i_lo   : lower register (multiply: multiplier / product low half,
//            divide: dividend shifting out MSB first / quotient shifting in)
//   i_b    : latched second operand (multiplicand / divisor)
//   o_hi, o_lo : register values after this iteration
module mdu_step #(
  parameter int W = 4
) (
  input  logic         i_div,
  input  logic [W:0]   i_hi,
  input  logic [W-1:0] i_lo,
  input  logic [W-1:0] i_b,
  output logic [W:0]   o_hi,
  output logic [W-1:0] o_lo
);
  logic [W:0]   w_sum;   // multiply partial sum incl. carry
  logic [W:0]   w_shl;   // remainder shifted left with next dividend bit
  logic [W+1:0] w_diff;  // trial subtraction; MSB is the borrow
  logic         w_q;

  always_comb begin
    // i_hi[W] stays 0 while multiplying, so adding the full register is exact.
    w_sum  = i_hi + (i_lo[0] ? {1'b0, i_b} : '0);
    w_shl  = {i_hi[W-1:0], i_lo[W-1]};
    w_diff = {1'b0, w_shl} - {2'b00, i_b};
    w_q    = ~w_diff[W+1];
    if (i_div) begin
      // Divisor 0 never borrows: quotient fills with ones, remainder collects a.
      o_hi = w_q ? w_diff[W:0] : w_shl;
      o_lo = {i_lo[W-2:0], w_q};
    end else begin
      // Shift the {carry, sum, lo} accumulator right by one; LSB of lo retires.
      o_hi = {1'b0, w_sum[W:1]};
      o_lo = {w_sum[0], i_lo[W-1:1]};
    end
  end
endmodule

// File: rtl/seq_mdu.sv
// seq_mdu: sequential unsigned multiply/divide unit writing its result to a
// register file. One operand bit is processed per RUN cycle (dataWidth cycles),
// followed by a single write-back cycle.
//   clk  : system clock, posedge
//   rst  : asynchronous, active-high reset
//   bus  : seq_mdu_if slave -- start/op/a/b/dst in; busy/done/we/wa/wd out
module seq_mdu
  import seq_mdu_pkg::*;
#(
  parameter int dataWidth = 4,
  parameter int addressN  = 3
) (
  input  logic      clk,
  input  logic      rst,
  seq_mdu_if.slave  bus
);
  localparam int CW = ($clog2(dataWidth) > 0) ? $clog2(dataWidth) : 1;

  logic [1:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [1:0]           r_op;
  logic [addressN-1:0]  r_dst;
  logic [dataWidth-1:0] r_b;
  logic [dataWidth:0]   r_hi;
  logic [dataWidth-1:0] r_lo;

  logic [dataWidth:0]   w_hi;
  logic [dataWidth-1:0] w_lo;
  logic [dataWidth-1:0] w_res;
  logic                 w_wb;

  mdu_step #(.W(dataWidth)) u_step (
    .i_div (op_is_div(r_op)),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .i_b   (r_b),
    .o_hi  (w_hi),
    .o_lo  (w_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_dst   <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_op    <= bus.op;
          r_dst   <= bus.dst;
          r_b     <= bus.b;
          r_hi    <= '0;
          r_lo    <= bus.a;
          r_cnt   <= CW'(dataWidth - 1);
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_hi <= w_hi;
          r_lo <= w_lo;
          if (r_cnt == '0) r_state <= ST_WB;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;  // WB lasts exactly one cycle
      endcase
    end
  end

  always_comb begin
    case (r_op)
      OP_MUL:  w_res = r_lo;
      OP_MULH: w_res = r_hi[dataWidth-1:0];
      OP_DIV:  w_res = r_lo;
      default: w_res = r_hi[dataWidth-1:0];
    endcase
  end

  // Outputs decode straight from state so reset clears them without a clock.
  assign w_wb     = (r_state == ST_WB);
  assign bus.busy = (r_state == ST_RUN) || w_wb;
  assign bus.we   = w_wb;
  assign bus.done = w_wb;
  assign bus.wa   = w_wb ? r_dst : '0;
  assign bus.wd   = w_wb ? w_res : '0;
endmodule
